// File: rtl/tug_pkg.sv
// Shared encodings for the Tug-of-War play field and its master controller.
package tug_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ARMED = 2'b01,
        ST_PLAY  = 2'b10,
        ST_WON   = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_L    = 2'b01,
        WIN_R    = 2'b10
    } winner_t;

    localparam logic [1:0] LC_DARK   = 2'b00;
    localparam logic [1:0] LC_CENTRE = 2'b01;
    localparam logic [1:0] LC_ROPE   = 2'b10;
    localparam logic [1:0] LC_ALL    = 2'b11;

    function automatic int pos_width(input int num_leds);
        return (num_leds > 2) ? $clog2(num_leds) : 1;
    endfunction

endpackage

// File: rtl/tug_rope_if.sv
// Controller <-> play-field link: display/round control in, round-end pulse out.
interface tug_rope_if;
    logic       leds_on;
    logic [1:0] leds_ctrl;
    logic       clear;
    logic       winrnd;

    modport master (output leds_on, output leds_ctrl, output clear, input winrnd);
    modport slave  (input leds_on, input leds_ctrl, input clear, output winrnd);
endinterface

// File: rtl/tug_led_decode.sv
// Pure mapping of display mode, rope position and winner onto the LED bar.
module tug_led_decode
    import tug_pkg::*;
#(
    parameter int NUM_LEDS = 7,
    parameter int PW       = 3
) (
    input  logic                leds_on,
    input  logic [1:0]          leds_ctrl,
    input  logic [PW-1:0]       pos,
    input  winner_t             winner,
    output logic [NUM_LEDS-1:0] pattern
);

    localparam int C = (NUM_LEDS - 1) / 2;

    always_comb begin
        pattern = '0;
        if (leds_on) begin
            case (leds_ctrl)
                LC_CENTRE: pattern[C] = 1'b1;
                LC_ALL:    pattern = '1;
                LC_ROPE: begin
                    case (winner)
                        WIN_L:   pattern[NUM_LEDS-1] = 1'b1;
                        WIN_R:   pattern[0] = 1'b1;
                        default: pattern[pos] = 1'b1;
                    endcase
                end
                default:   pattern = '0;
            endcase
        end
    end

endmodule

// File: rtl/tug_rope.sv
// Play-field stage: rope position, false-start and win detection, scores, LED bar.
//   state    | meaning
//   ST_IDLE  | between rounds; rope recentred while clear is high
//   ST_ARMED | dark period, any single press is a false start
//   ST_PLAY  | rope moves on single rising button edges
//   ST_WON   | winner latched, buttons ignored until controller clears
module tug_rope
    import tug_pkg::*;
#(
    parameter int NUM_LEDS = 7,
    parameter int SCORE_W  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pbl,
    input  logic                pbr,
    tug_rope_if.slave           ctl,
    output logic [NUM_LEDS-1:0] leds,
    output logic [SCORE_W-1:0]  score_l,
    output logic [SCORE_W-1:0]  score_r
);

    localparam int            PW      = pos_width(NUM_LEDS);
    localparam logic [PW-1:0] POS_C   = PW'((NUM_LEDS - 1) / 2);
    localparam logic [PW-1:0] POS_MAX = PW'(NUM_LEDS - 1);

    state_t                state, state_nxt;
    winner_t               winner, winner_nxt;
    logic [PW-1:0]         pos, pos_nxt;
    logic                  pbl_q, pbr_q;
    logic                  win_l, win_r;
    logic                  winrnd_q;
    logic [NUM_LEDS-1:0]   led_pat;

    logic ev_l, ev_r, one_l, one_r, rope_mode;
    assign ev_l      = pbl & ~pbl_q;
    assign ev_r      = pbr & ~pbr_q;
    assign one_l     = ev_l & ~ev_r;
    assign one_r     = ev_r & ~ev_l;
    assign rope_mode = ctl.leds_on && (ctl.leds_ctrl == LC_ROPE);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (!ctl.clear) begin
                    if (!ctl.leds_on)   state_nxt = ST_ARMED;
                    else if (rope_mode) state_nxt = ST_PLAY;
                end
            end
            ST_ARMED: begin
                if (ctl.clear)           state_nxt = ST_IDLE;
                else if (win_l || win_r) state_nxt = ST_WON;
                else if (rope_mode)      state_nxt = ST_PLAY;
            end
            ST_PLAY: begin
                if (ctl.clear)           state_nxt = ST_IDLE;
                else if (win_l || win_r) state_nxt = ST_WON;
            end
            ST_WON: begin
                if (ctl.clear && (ctl.leds_ctrl != LC_ROPE)) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Leaving a round on clear also recentres, so a one-cycle clear pulse is enough.
    always_comb begin
        pos_nxt    = pos;
        winner_nxt = winner;
        win_l      = 1'b0;
        win_r      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ctl.clear) pos_nxt = POS_C;
            end
            ST_ARMED: begin
                if (!ctl.clear) begin
                    if (one_l)      win_r = 1'b1;
                    else if (one_r) win_l = 1'b1;
                end
            end
            ST_PLAY: begin
                if (ctl.clear) begin
                    pos_nxt = POS_C;
                end else if (one_l && (pos != POS_MAX)) begin
                    pos_nxt = pos + 1'b1;
                    win_l   = (pos_nxt == POS_MAX);
                end else if (one_r && (pos != '0)) begin
                    pos_nxt = pos - 1'b1;
                    win_r   = (pos_nxt == '0);
                end
            end
            ST_WON: begin
                if (ctl.clear && (ctl.leds_ctrl != LC_ROPE)) begin
                    winner_nxt = WIN_NONE;
                    pos_nxt    = POS_C;
                end
            end
            default: pos_nxt = POS_C;
        endcase
        if (win_l)      winner_nxt = WIN_L;
        else if (win_r) winner_nxt = WIN_R;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pos      <= POS_C;
            winner   <= WIN_NONE;
            winrnd_q <= 1'b0;
            score_l  <= '0;
            score_r  <= '0;
            pbl_q    <= 1'b1;
            pbr_q    <= 1'b1;
            leds     <= '0;
        end else begin
            pos      <= pos_nxt;
            winner   <= winner_nxt;
            winrnd_q <= win_l | win_r;
            pbl_q    <= pbl;
            pbr_q    <= pbr;
            leds     <= led_pat;
            if (win_l && (score_l != '1)) score_l <= score_l + 1'b1;
            if (win_r && (score_r != '1)) score_r <= score_r + 1'b1;
        end
    end

    assign ctl.winrnd = winrnd_q;

    tug_led_decode #(
        .NUM_LEDS (NUM_LEDS),
        .PW       (PW)
    ) u_led_decode (
        .leds_on   (ctl.leds_on),
        .leds_ctrl (ctl.leds_ctrl),
        .pos       (pos),
        .winner    (winner),
        .pattern   (led_pat)
    );

endmodule

// File: tb/tb_tug_rope.sv
// Directed bench for tug_rope with NUM_LEDS=7 and SCORE_W=2 (saturates at 3).
module tb_tug_rope;
    import tug_pkg::*;

    logic       clk;
    logic       rst;
    logic       pbl;
    logic       pbr;
    logic [6:0] leds;
    logic [1:0] score_l;
    logic [1:0] score_r;
    int         n_checks;
    int         n_fail;
    logic       w;

    tug_rope_if u_if ();

    tug_rope #(
        .NUM_LEDS (7),
        .SCORE_W  (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .pbl     (pbl),
        .pbr     (pbr),
        .ctl     (u_if.slave),
        .leds    (leds),
        .score_l (score_l),
        .score_r (score_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One full press; o_w is winrnd seen right after the edge that sampled the rise.
    task automatic press(input bit left, output logic o_w);
        if (left) pbl = 1'b1;
        else      pbr = 1'b1;
        step(1);
        o_w = u_if.winrnd;
        pbl = 1'b0;
        pbr = 1'b0;
        step(1);
    endtask

    task automatic ctrl(input logic c, input logic on, input logic [1:0] lc);
        u_if.clear     = c;
        u_if.leds_on   = on;
        u_if.leds_ctrl = lc;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        pbl = 1'b0;
        pbr = 1'b0;
        ctrl(1'b1, 1'b0, LC_DARK);
        step(2);
        check_eq("rst_winrnd", {31'd0, u_if.winrnd}, 0);
        check_eq("rst_score_l", {30'd0, score_l}, 0);
        check_eq("rst_score_r", {30'd0, score_r}, 0);
        check_eq("rst_leds", {25'd0, leds}, 0);

        // Left player pulls the rope from centre to the left end
        rst = 1'b0;
        ctrl(1'b0, 1'b1, LC_ROPE);
        step(1);
        check_eq("play_centre", {25'd0, leds}, 32'b0001000);
        press(1'b1, w);
        check_eq("p1_winrnd", {31'd0, w}, 0);
        check_eq("p1_leds", {25'd0, leds}, 32'b0010000);
        press(1'b1, w);
        check_eq("p2_winrnd", {31'd0, w}, 0);
        check_eq("p2_leds", {25'd0, leds}, 32'b0100000);
        press(1'b1, w);
        check_eq("p3_winrnd", {31'd0, w}, 1);
        check_eq("p3_winrnd_gone", {31'd0, u_if.winrnd}, 0);
        check_eq("p3_score_l", {30'd0, score_l}, 1);
        check_eq("p3_leds", {25'd0, leds}, 32'b1000000);
        press(1'b0, w);
        check_eq("won_ignore", {31'd0, w}, 0);
        check_eq("won_pos_frozen", {25'd0, leds}, 32'b1000000);

        ctrl(1'b1, 1'b1, LC_ALL);
        step(1);
        check_eq("mode_all", {25'd0, leds}, 32'b1111111);
        ctrl(1'b1, 1'b1, LC_CENTRE);
        step(1);
        check_eq("mode_centre", {25'd0, leds}, 32'b0001000);
        ctrl(1'b1, 1'b0, LC_ALL);
        step(1);
        check_eq("mode_off", {25'd0, leds}, 0);

        // False start during the dark period
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        ctrl(1'b0, 1'b0, LC_DARK);
        step(1);
        press(1'b1, w);
        check_eq("fs_winrnd", {31'd0, w}, 1);
        check_eq("fs_score_r", {30'd0, score_r}, 1);
        check_eq("fs_score_l", {30'd0, score_l}, 0);
        press(1'b1, w);
        check_eq("fs_no_second_l", {31'd0, w}, 0);
        press(1'b0, w);
        check_eq("fs_no_second_r", {31'd0, w}, 0);
        check_eq("fs_score_r_hold", {30'd0, score_r}, 1);

        // Simultaneous edges, held button, and a right-side win at index 0
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        ctrl(1'b0, 1'b1, LC_ROPE);
        step(1);
        pbl = 1'b1;
        pbr = 1'b1;
        step(1);
        check_eq("both_winrnd", {31'd0, u_if.winrnd}, 0);
        pbl = 1'b0;
        pbr = 1'b0;
        step(1);
        check_eq("both_no_move", {25'd0, leds}, 32'b0001000);
        pbl = 1'b1;
        step(10);
        pbl = 1'b0;
        step(1);
        check_eq("held_one_move", {25'd0, leds}, 32'b0010000);
        for (int i = 0; i < 4; i++) begin
            press(1'b0, w);
            check_eq("r_pull_winrnd", {31'd0, w}, (i == 3) ? 32'd1 : 32'd0);
        end
        check_eq("r_win_leds", {25'd0, leds}, 32'b0000001);
        check_eq("r_win_score_r", {30'd0, score_r}, 1);

        // Saturating left score over five rounds
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        ctrl(1'b1, 1'b1, LC_ALL);
        step(1);
        for (int r = 1; r <= 5; r++) begin
            ctrl(1'b0, 1'b1, LC_ROPE);
            step(1);
            press(1'b1, w);
            press(1'b1, w);
            press(1'b1, w);
            check_eq("sat_winrnd", {31'd0, w}, 1);
            ctrl(1'b1, 1'b1, LC_ALL);
            step(1);
            check_eq("sat_score_l", {30'd0, score_l}, (r < 3) ? r : 3);
        end

        // Reset mid-round with the left button held through it
        ctrl(1'b0, 1'b1, LC_ROPE);
        step(1);
        press(1'b1, w);
        press(1'b1, w);
        check_eq("mid_pos5", {25'd0, leds}, 32'b0100000);
        pbl = 1'b1;
        rst = 1'b1;
        step(1);
        check_eq("mid_rst_winrnd", {31'd0, u_if.winrnd}, 0);
        check_eq("mid_rst_score_l", {30'd0, score_l}, 0);
        check_eq("mid_rst_score_r", {30'd0, score_r}, 0);
        rst = 1'b0;
        ctrl(1'b1, 1'b1, LC_ROPE);
        step(1);
        check_eq("mid_rst_centre", {25'd0, leds}, 32'b0001000);
        ctrl(1'b0, 1'b1, LC_ROPE);
        step(3);
        check_eq("mid_held_no_edge", {25'd0, leds}, 32'b0001000);
        pbl = 1'b0;
        step(1);
        press(1'b1, w);
        check_eq("mid_repress_winrnd", {31'd0, w}, 0);
        check_eq("mid_repress_move", {25'd0, leds}, 32'b0010000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
